mac_dot_seq: RTL and testbench

- Sequencer that drives one MAC datapath (clr/run, signed in1/in2, total/err) to compute a signed dot product of two length-N vectors.
- Operands come from two synchronous-read operand buffers (A, B) with 1-cycle read latency.
- A host issues start with base addresses and length. The block returns the accumulated result with a done pulse and a sticky overflow flag.
- Sits between the top-level matrix controller and each MAC lane.

---
 rtl/mac_dot_seq.sv | 100 ++++++++++
 tb/tb_mac_dot_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mac_dot_seq.sv
// mac_dot_seq: drives a 2-stage MAC over operand buffers A/B to form a signed dot product.
// Define MAC_DOT_SEQ_CYCLE_CNT_EN to add the op_cycles latency report output.
module mac_dot_seq #(
    parameter int DATA_WIDTH  = 16,
    parameter int ACCUM_WIDTH = 2*DATA_WIDTH,
    parameter int ADDR_WIDTH  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
`ifdef MAC_DOT_SEQ_CYCLE_CNT_EN
    output logic [15:0]            op_cycles,
`endif
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDR_WIDTH-1:0]  len,
    input  logic [ADDR_WIDTH-1:0]  base_a,
    input  logic [ADDR_WIDTH-1:0]  base_b,
    output logic                   busy,
    output logic                   done,
    output logic [ACCUM_WIDTH-1:0] result,
    output logic                   result_err,
    output logic                   rd_en,
    output logic [ADDR_WIDTH-1:0]  a_addr,
    output logic [ADDR_WIDTH-1:0]  b_addr,
    input  logic [DATA_WIDTH-1:0]  a_data,
    input  logic [DATA_WIDTH-1:0]  b_data,
    output logic                   mac_clr,
    output logic                   mac_run,
    output logic [DATA_WIDTH-1:0]  mac_in1,
    output logic [DATA_WIDTH-1:0]  mac_in2,
    input  logic [ACCUM_WIDTH-1:0] mac_total,
    input  logic                   mac_err
);
    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, FLUSH, DRAIN, DONE} state_t;
    state_t                 state_q;
    logic [ADDR_WIDTH-1:0]  len_q, base_a_q, base_b_q, idx_q, idx_d, off;
    logic [ACCUM_WIDTH-1:0] result_q;
    logic                   err_q, more;
    assign idx_d = idx_q + ADDR_WIDTH'(1);
    // idx never exceeds len-1 in STREAM, so inequality is enough to detect the last element
    assign more = idx_d != len_q;
    assign busy = state_q != IDLE;
    assign done = state_q == DONE;
    assign mac_clr = abort || state_q == CLEAR;
    assign mac_run = !abort && (state_q == STREAM || state_q == FLUSH);
    assign rd_en = !abort && ((state_q == CLEAR && len_q != '0) || (state_q == STREAM && more));
    assign off = state_q == STREAM ? idx_d : '0;
    assign a_addr = rd_en ? base_a_q + off : '0;
    assign b_addr = rd_en ? base_b_q + off : '0;
    assign mac_in1 = state_q == STREAM ? a_data : '0;
    assign mac_in2 = state_q == STREAM ? b_data : '0;
    assign result = result_q;
    assign result_err = err_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            len_q    <= '0;
            base_a_q <= '0;
            base_b_q <= '0;
            idx_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else if (abort) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    len_q    <= len;
                    base_a_q <= base_a;
                    base_b_q <= base_b;
                    idx_q    <= '0;
                    state_q  <= CLEAR;
                end
                CLEAR:  state_q <= len_q != '0 ? STREAM : FLUSH;
                STREAM: if (more) idx_q <= idx_d; else state_q <= FLUSH;
                FLUSH:  state_q <= DRAIN;
                DRAIN: begin
                    result_q <= mac_total;
                    err_q    <= mac_err;
                    state_q  <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`ifdef MAC_DOT_SEQ_CYCLE_CNT_EN
    logic [15:0] cnt_q, op_cycles_q;
    assign op_cycles = op_cycles_q;
    // cnt_q lags the busy-cycle count by one, hence the +1 when loading in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q       <= '0;
            op_cycles_q <= '0;
        end else begin
            cnt_q <= state_q == IDLE ? '0 : cnt_q + 16'd1;
            if (!abort && state_q == DONE) op_cycles_q <= cnt_q + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mac_dot_seq.sv
// tb_mac_dot_seq: directed vectors with a result scoreboard, buffer models and a 2-stage MAC model.
module tb_mac_dot_seq;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [7:0]  len = '0, base_a = '0, base_b = '0;
    logic        busy, done, result_err, rd_en, mac_clr, mac_run, mac_err;
    logic [31:0] result, mac_total;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_data = '0, b_data = '0, mac_in1, mac_in2;
`ifdef MAC_DOT_SEQ_CYCLE_CNT_EN
    logic [15:0] op_cycles;
`endif
    logic [15:0] mem_a [256];
    logic [15:0] mem_b [256];
    int cyc = 0, vecs = 0, errs = 0;
    typedef struct {logic [31:0] res; logic err; int cyc0; int n;} exp_t;
    exp_t sb[$];
    exp_t me;
    logic signed [31:0] prod_q = '0, tot_q = '0, sum;
    logic err_q = 1'b0;

    mac_dot_seq dut (
        .clk(clk), .rst(rst),
`ifdef MAC_DOT_SEQ_CYCLE_CNT_EN
        .op_cycles(op_cycles),
`endif
        .start(start), .abort(abort), .len(len), .base_a(base_a), .base_b(base_b),
        .busy(busy), .done(done), .result(result), .result_err(result_err),
        .rd_en(rd_en), .a_addr(a_addr), .b_addr(b_addr), .a_data(a_data), .b_data(b_data),
        .mac_clr(mac_clr), .mac_run(mac_run), .mac_in1(mac_in1), .mac_in2(mac_in2),
        .mac_total(mac_total), .mac_err(mac_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (rd_en) begin
        a_data <= mem_a[a_addr];
        b_data <= mem_b[b_addr];
    end
    assign sum = tot_q + prod_q;
    always @(posedge clk) begin
        if (rst || mac_clr) begin
            prod_q <= '0;
            tot_q  <= '0;
            err_q  <= 1'b0;
        end else if (mac_run) begin
            prod_q <= $signed(mac_in1) * $signed(mac_in2);
            tot_q  <= sum;
            if (tot_q[31] == prod_q[31] && sum[31] != tot_q[31]) err_q <= 1'b1;
        end
    end
    assign mac_total = tot_q;
    assign mac_err = err_q;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) if (!rst && done) begin
        if (sb.size() == 0) begin
            vecs++;
            errs++;
            $display("FAIL unexpected_done: got done=1 expected no done (result %0h)", result);
        end else begin
            me = sb.pop_front();
            chk("result", result, me.res);
            chk("result_err", {31'b0, result_err}, {31'b0, me.err});
            chk("latency", cyc - me.cyc0, me.n + 4);
        end
    end

    task automatic run_op(input int n, input logic [7:0] ba, input logic [7:0] bb,
                          input logic [31:0] er, input logic ee, input bit poke);
        int t = 0, rds = 0, clrs = 0, runs = 0;
        @(negedge clk);
        len = 8'(n);
        base_a = ba;
        base_b = bb;
        start = 1'b1;
        sb.push_back('{er, ee, cyc, n});
        @(negedge clk);
        start = 1'b0;
        len = 8'hAA;
        base_a = 8'h33;
        base_b = 8'h77;
        while (!done && t < 64) begin
            clrs += int'(mac_clr);
            runs += int'(mac_run);
            if (rd_en) begin
                chk("a_addr", {24'b0, a_addr}, {24'b0, 8'(ba + 8'(rds))});
                chk("b_addr", {24'b0, b_addr}, {24'b0, 8'(bb + 8'(rds))});
                rds++;
            end
            start = poke && t == 2;
            @(negedge clk);
            t++;
        end
        start = 1'b0;
        chk("done_seen", {31'b0, done}, 32'd1);
        chk("rd_count", rds, n);
        chk("clr_count", clrs, 1);
        chk("run_count", runs, n + 1);
        @(negedge clk);
        chk("busy_after", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_a[i] = '0;
            mem_b[i] = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_rd_en", {31'b0, rd_en}, 32'd0);
        chk("rst_mac_clr", {31'b0, mac_clr}, 32'd0);
        chk("rst_mac_run", {31'b0, mac_run}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_err", {31'b0, result_err}, 32'd0);
        chk("rst_a_addr", {24'b0, a_addr}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_a[i] = 16'(i + 1);
            mem_b[16 + i] = 16'(i + 5);
        end
        run_op(4, 8'h00, 8'h10, 32'd70, 1'b0, 1'b0);
        run_op(0, 8'h40, 8'h50, 32'd0, 1'b0, 1'b0);
        mem_a[32] = 16'hFFFD; mem_a[33] = 16'd7;
        mem_b[48] = 16'd4;    mem_b[49] = 16'hFFFE;
        run_op(2, 8'd32, 8'd48, 32'hFFFFFFE6, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            mem_a[64 + i] = 16'h8000;
            mem_b[80 + i] = 16'h8000;
        end
        run_op(3, 8'd64, 8'd80, 32'hC0000000, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            mem_a[96 + i] = 16'd3;
            mem_b[96 + i] = 16'd3;
        end
        @(negedge clk);
        len = 8'd5; base_a = 8'd96; base_b = 8'd96; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        abort = 1'b1;
        #1;
        chk("abort_clr", {31'b0, mac_clr}, 32'd1);
        chk("abort_run", {31'b0, mac_run}, 32'd0);
        chk("abort_rd", {31'b0, rd_en}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_idle", {31'b0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("abort_result_held", result, 32'hC0000000);
        chk("abort_err_held", {31'b0, result_err}, 32'd1);
        mem_a[110] = 16'd9; mem_b[120] = 16'd9;
        run_op(1, 8'd110, 8'd120, 32'd81, 1'b0, 1'b0);
        mem_a[254] = 16'd10; mem_a[255] = 16'hFFFF;
        for (int i = 0; i < 4; i++) mem_b[200 + i] = 16'(i + 1);
        run_op(4, 8'hFE, 8'd200, 32'd19, 1'b0, 1'b1);
`ifdef MAC_DOT_SEQ_CYCLE_CNT_EN
        chk("op_cycles", {16'b0, op_cycles}, 32'd8);
`endif
        abort = 1'b1;
        #1;
        chk("idle_abort_clr", {31'b0, mac_clr}, 32'd1);
        chk("idle_abort_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        abort = 1'b0;
        repeat (2) @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
